// File: rtl/bin_2_rns.sv
// -----------------------------------------------------------------------------
// bin_2_rns
//   Converts a 32-bit two's-complement binary operand into four residues,
//   one per channel, using floor-mod semantics. A negative n therefore still
//   gives a residue in 0..m-1 (for example -1 mod 7 = 6). Each channel has
//   its own modulus input. The supported modulus range is 2..8. Any other
//   modulus value (0, 1, 9..15) gives a residue of 0.
//
//   The residue logic is purely combinational from n and mod_k into one bank
//   of output registers. Latency is exactly one clock. Throughput is one
//   operand per clock.
//
// Ports
//   clk                 : single clock, rising edge
//   reset               : synchronous, active-low; clears every residue
//   n [31:0]            : signed binary operand, shared by all channels
//   in_valid            : (BIN_2_RNS_VALID_EN only) operand qualifier
//   mod_1..mod_4 [3:0]  : unsigned modulus for channels 1..4
//   out_mod_1..4 [2:0]  : registered residues for channels 1..4
//   out_valid           : (BIN_2_RNS_VALID_EN only) in_valid delayed 1 clock
//
// Configuration
//   BIN_2_RNS_VALID_EN  : when defined, adds in_valid and out_valid.
//                         The residues load only while in_valid=1 and
//                         otherwise hold their value.
//
// Valid semantics (BIN_2_RNS_VALID_EN): there is no ready/backpressure.
//   An operand is accepted at every rising edge where in_valid=1. Its
//   residues and out_valid=1 appear after that edge.
// -----------------------------------------------------------------------------
module bin_2_rns (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] n,
`ifdef BIN_2_RNS_VALID_EN
  input  logic        in_valid,
`endif
  input  logic [3:0]  mod_1,
  input  logic [3:0]  mod_2,
  input  logic [3:0]  mod_3,
  input  logic [3:0]  mod_4,
  output logic [2:0]  out_mod_1,
  output logic [2:0]  out_mod_2,
  output logic [2:0]  out_mod_3,
  output logic [2:0]  out_mod_4
`ifdef BIN_2_RNS_VALID_EN
  ,
  output logic        out_valid
`endif
);

  // Floor-mod of a signed 32-bit value by a 4-bit modulus.
  // The truncating remainder lies in (-m, m). A negative remainder is
  // folded up by adding m. This works across the full 32-bit range,
  // including -2^31, because the arithmetic is done in 33 bits.
  function automatic logic [2:0] floor_mod(input logic [31:0] val,
                                           input logic [3:0]  m);
    logic signed [32:0] sv;
    logic signed [32:0] sm;
    logic signed [32:0] r;
    sv = {val[31], val};
    sm = {29'd0, m};
    r  = '0;
    floor_mod = 3'd0;
    if ((m >= 4'd2) && (m <= 4'd8)) begin
      r = sv % sm;
      if (r < 0) begin
        r = r + sm;
      end
      floor_mod = r[2:0];
    end
  endfunction

  logic [3:0] mod_a [4];
  logic [2:0] res_d [4];
  logic [2:0] res_q [4];
  logic       load;

  assign mod_a[0] = mod_1;
  assign mod_a[1] = mod_2;
  assign mod_a[2] = mod_3;
  assign mod_a[3] = mod_4;

`ifdef BIN_2_RNS_VALID_EN
  logic valid_q;
  assign load      = in_valid;
  assign out_valid = valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
    end
  end
`else
  assign load = 1'b1;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      res_d[k] = floor_mod(n, mod_a[k]);
    end
  end

  // The reset has priority over new data. An in-flight result is simply
  // overwritten, because the output registers are the only state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        res_q[k] <= 3'd0;
      end
    end else if (load) begin
      for (int k = 0; k < 4; k++) begin
        res_q[k] <= res_d[k];
      end
    end
  end

  assign out_mod_1 = res_q[0];
  assign out_mod_2 = res_q[1];
  assign out_mod_3 = res_q[2];
  assign out_mod_4 = res_q[3];

endmodule

// File: tb/tb_bin_2_rns.sv
// -----------------------------------------------------------------------------
// tb_bin_2_rns
//   Directed bench for bin_2_rns. Inputs are driven on the falling edge.
//   Outputs are sampled 1 ns after the following rising edge. This gives
//   the 1-clock alignment between an operand and its residues.
// -----------------------------------------------------------------------------
module tb_bin_2_rns;

  logic        clk;
  logic        reset;
  logic [31:0] n;
  logic [3:0]  mod_1, mod_2, mod_3, mod_4;
  logic [2:0]  out_mod_1, out_mod_2, out_mod_3, out_mod_4;
`ifdef BIN_2_RNS_VALID_EN
  logic        in_valid;
  logic        out_valid;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bin_2_rns dut (
    .clk       (clk),
    .reset     (reset),
    .n         (n),
`ifdef BIN_2_RNS_VALID_EN
    .in_valid  (in_valid),
`endif
    .mod_1     (mod_1),
    .mod_2     (mod_2),
    .mod_3     (mod_3),
    .mod_4     (mod_4),
    .out_mod_1 (out_mod_1),
    .out_mod_2 (out_mod_2),
    .out_mod_3 (out_mod_3),
    .out_mod_4 (out_mod_4)
`ifdef BIN_2_RNS_VALID_EN
    ,
    .out_valid (out_valid)
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [2:0] e1, input logic [2:0] e2,
                        input logic [2:0] e3, input logic [2:0] e4);
    check({tag, ".m1"}, out_mod_1, e1);
    check({tag, ".m2"}, out_mod_2, e2);
    check({tag, ".m3"}, out_mod_3, e3);
    check({tag, ".m4"}, out_mod_4, e4);
  endtask

  // Independent reference model for the sweep. It is the textbook
  // floor-mod on 32-bit ints.
  function automatic logic [2:0] ref_mod(input int a, input int m);
    int r;
    r = a % m;
    if (r < 0) r = r + m;
    return r[2:0];
  endfunction

  // ---------------- driver ----------------
  // Apply the operand and moduli, clock once, then sample just after the edge.
  task automatic apply(input logic rst_n, input logic [31:0] val);
    @(negedge clk);
    reset = rst_n;
    n     = val;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mods(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    mod_1 = a; mod_2 = b; mod_3 = c; mod_4 = d;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    n     = 32'd419;
`ifdef BIN_2_RNS_VALID_EN
    in_valid = 1'b1;
`endif
    set_mods(4'd7, 4'd5, 4'd3, 4'd2);

    // Reset held for 3 clocks while n=419 is presented.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'd419);
      check4("reset_hold", 3'd0, 3'd0, 3'd0, 3'd0);
    end
    // First edge with reset released shows the inputs of that edge.
    apply(1'b1, 32'd419);
    check4("reset_release", 3'd6, 3'd4, 3'd2, 3'd1);
`ifdef BIN_2_RNS_VALID_EN
    check("out_valid_release", {2'b00, out_valid}, 3'd1);
`endif

    // Hand-computed vectors with moduli 7,5,3,2.
    apply(1'b1, 32'd0);
    check4("n_0", 3'd0, 3'd0, 3'd0, 3'd0);
    apply(1'b1, 32'd419);
    check4("n_419", 3'd6, 3'd4, 3'd2, 3'd1);
    apply(1'b1, -32'sd1);
    check4("n_m1", 3'd6, 3'd4, 3'd2, 3'd1);
    apply(1'b1, -32'sd419);
    check4("n_m419", 3'd1, 3'd1, 3'd1, 3'd1);
    apply(1'b1, -32'sd420);
    check4("n_m420", 3'd0, 3'd0, 3'd0, 3'd0);

    // Full-range extremes.
    apply(1'b1, 32'h7FFF_FFFF);
    check4("n_max", 3'd1, 3'd2, 3'd1, 3'd1);
    apply(1'b1, 32'h8000_0000);
    check4("n_min", 3'd5, 3'd2, 3'd1, 3'd0);

    // Outputs must not follow an input change before the next edge.
    n = 32'd419;
    #2;
    check4("no_comb_path", 3'd5, 3'd2, 3'd1, 3'd0);

    // Modulus edge cases. The new moduli take effect at the very next edge.
    set_mods(4'd8, 4'd0, 4'd1, 4'd15);
    apply(1'b1, -32'sd1);
    check4("mod_edge_m1", 3'd7, 3'd0, 3'd0, 3'd0);
    apply(1'b1, 32'd419);
    check4("mod_edge_419", 3'd3, 3'd0, 3'd0, 3'd0);

    // Sweep n from -420 to 419 against the floor-mod model. Reset is pulsed
    // for one edge mid-sweep. Only that cycle must read 0.
    set_mods(4'd7, 4'd5, 4'd3, 4'd2);
    for (int v = -420; v <= 419; v++) begin
      apply((v == 37) ? 1'b0 : 1'b1, v);
      if (v == 37) begin
        check4("sweep_reset", 3'd0, 3'd0, 3'd0, 3'd0);
      end else begin
        check4($sformatf("sweep_%0d", v), ref_mod(v, 7), ref_mod(v, 5),
               ref_mod(v, 3), ref_mod(v, 2));
      end
    end

`ifdef BIN_2_RNS_VALID_EN
    // With in_valid=0 and n changing, the outputs hold and out_valid drops.
    apply(1'b1, 32'd419);
    check4("vld_load_419", 3'd6, 3'd4, 3'd2, 3'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'd100 + 32'(i));
      check4("vld_hold", 3'd6, 3'd4, 3'd2, 3'd1);
      check("vld_out_valid_0", {2'b00, out_valid}, 3'd0);
    end
    @(negedge clk);
    in_valid = 1'b1;
    apply(1'b1, -32'sd1);
    check4("vld_n_m1", 3'd6, 3'd4, 3'd2, 3'd1);
    check("vld_out_valid_1", {2'b00, out_valid}, 3'd1);
    @(negedge clk);
    in_valid = 1'b0;
    apply(1'b1, 32'd0);
    check4("vld_hold2", 3'd6, 3'd4, 3'd2, 3'd1);
    check("vld_out_valid_drop", {2'b00, out_valid}, 3'd0);
`endif

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_2_rns.md
BIN_2_RNS -- requirements
Module: bin_2_rns

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have the port `n`, input, 32 bits: binary operand, two's-complement signed.
REQ-004 The block SHALL have the ports `mod_1`, `mod_2`, `mod_3`, `mod_4`, input, 4 bits each: unsigned modulus for channel k.
REQ-005 The block SHALL have the ports `out_mod_1`, `out_mod_2`, `out_mod_3`, `out_mod_4`, output, 3 bits each: registered residue for channel k.
REQ-006 The port order SHALL be clk, reset, n, mod_1..mod_4, out_mod_1..out_mod_4.

Function
REQ-007 Each channel k SHALL compute r_k = n mod m_k, where m_k = mod_k and n is a signed integer, using floor semantics so that 0 <= r_k <= m_k-1 for every n, including negative n.
REQ-008 The supported modulus range SHALL be 2..8.
REQ-009 For mod_k = 0, mod_k = 1 or mod_k > 8, out_mod_k SHALL be 0.
REQ-010 The full 32-bit range of n, from -2^31 to 2^31-1, SHALL be supported, not only the RNS dynamic range.
REQ-011 The latency SHALL be exactly 1 clock: n and mod_k sampled at rising edge t SHALL appear on out_mod_k after edge t and hold until edge t+1.
REQ-012 The throughput SHALL be one new operand per clock, with no stall and no handshake in the base build.
REQ-013 The four channels SHALL be independent; the same n feeds all four.
REQ-014 The residue path SHALL be purely combinational from n and mod_k into the output registers.
REQ-015 Changing mod_k SHALL take effect on the next edge, with no residual state.
REQ-016 The outputs SHALL change only on rising clk edges, with no combinational path from the inputs to the outputs.

Reset
REQ-017 When reset=0 at a rising edge, all out_mod_k SHALL become 3'd0; the reset has priority over new data.
REQ-018 On the first edge with reset=1, the outputs SHALL reflect the inputs at that edge.
REQ-019 A reset asserted mid-stream SHALL discard the in-flight result; there is no other internal state.

Configuration
REQ-020 With BIN_2_RNS_VALID_EN defined, the block SHALL add a 1-bit input `in_valid` after `n` and a 1-bit output `out_valid` after out_mod_4.
REQ-021 With BIN_2_RNS_VALID_EN defined, out_valid SHALL equal in_valid delayed one clock and SHALL reset to 0.
REQ-022 With BIN_2_RNS_VALID_EN defined, out_mod_k SHALL update only when in_valid=1 and otherwise hold.
REQ-023 Without BIN_2_RNS_VALID_EN, the ports in_valid and out_valid SHALL be absent and REQ-012 applies.

Verification
REQ-024 The bench SHALL apply moduli 7,5,3,2 and n=0, 419, -1, -419 and -420 and check the outputs one clock later:
- n=0 -> 0,0,0,0
- n=419 -> 6,4,2,1
- n=-1 -> 6,4,2,1
- n=-419 -> 1,1,1,1
- n=-420 -> 0,0,0,0
REQ-025 The bench SHALL apply moduli 7,5,3,2 with the extremes n=32'h7FFFFFFF -> 1,2,1,1 and n=32'h80000000 -> 5,2,1,0.
REQ-026 The bench SHALL sweep n from -420 to 419, one value per clock, and compare every output against a floor-mod model with 1-cycle alignment, requiring zero mismatches.
REQ-027 The bench SHALL cover modulus edge cases: mod_1=8 with n=-1 -> 7; mod_2=0 -> 0; mod_3=1 -> 0; mod_4=15 -> 0.
REQ-028 The bench SHALL cover reset: hold reset=0 for 3 clocks while n=419 -> all outputs 0; release reset -> 6,4,2,1 one edge later; assert reset for one edge mid-sweep -> outputs 0 for exactly that cycle.
REQ-029 With BIN_2_RNS_VALID_EN defined, the bench SHALL drive in_valid=0 with n changing -> outputs hold and out_valid=0, then in_valid=1 with n=-1 -> 6,4,2,1 and out_valid=1 after 1 clock.
